clock_break_controller: RTL

//  Clock-domain break FSM that drives the core clock enable and the break countdown timer.
//  - Halts the core on ebreak or a halt request.
//  - Supports single-stepping from a push-button.
//  - Resumes on a button press or, optionally, when the countdown times out.
//  - Sits in the clock block: consumes countdown_timed_up, drives countdown_enable.

---
 rtl/clock_break_controller_pkg.sv | 34 +++
 rtl/clock_break_controller_button_debouncer.sv | 67 ++++++
 rtl/clock_break_controller.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/clock_break_controller_pkg.sv
// ----------------------------------------------------------------------------
// clock_break_controller_pkg
//
// Purpose:
//   Shared definitions for the clock-domain break controller: the FSM state
//   encoding, the default debounce and step lengths, and a small helper that
//   says whether the core is allowed to advance in a given state.
//
// Contents:
//   BRK_STATE_W              width of the break FSM state register
//   brk_state_e              RUN / HALT / STEP state encoding
//   DEBOUNCE_CYCLES_DEFAULT  10 ms of stable button level at 50 MHz
//   STEP_CYCLES_DEFAULT      core cycles granted per step press
//   core_runs_in()           1 for states in which the core clock is enabled
// ----------------------------------------------------------------------------
package clock_break_controller_pkg;

    localparam int BRK_STATE_W = 2;

    typedef enum logic [BRK_STATE_W-1:0] {
        BRK_STATE_RUN  = 2'd0,
        BRK_STATE_HALT = 2'd1,
        BRK_STATE_STEP = 2'd2
    } brk_state_e;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
    localparam int STEP_CYCLES_DEFAULT     = 1;

    // The core only advances in RUN and STEP.
    function automatic logic core_runs_in(input brk_state_e state);
        return (state == BRK_STATE_RUN) || (state == BRK_STATE_STEP);
    endfunction

endpackage

// File: rtl/clock_break_controller_button_debouncer.sv
// ----------------------------------------------------------------------------
// button_debouncer
//
// Purpose:
//   Turns a raw, asynchronous, bouncing push-button into a clean one-cycle
//   press pulse. The raw level goes through a 2-FF synchronizer. The
//   debounced level only follows it after DEBOUNCE_CYCLES consecutive
//   samples that differ from the current debounced level. A press is the
//   rising edge of the debounced level.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable samples needed to accept a change
//
// Ports:
//   clock_50mhz   in   system clock
//   reset_n       in   asynchronous active-low reset
//   button_raw    in   raw active-high button level
//   button_press  out  registered one-cycle pulse on an accepted press
// ----------------------------------------------------------------------------
module button_debouncer
    import clock_break_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clock_50mhz,
    input  logic reset_n,
    input  logic button_raw,
    output logic button_press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_meta;
    logic          sync_level;
    logic          debounced;
    logic [CW-1:0] stable_count;

    // Synchronizer, debounce counter and press pulse. The counter tracks
    // how long the synchronized level has disagreed with the debounced
    // level; any agreeing sample restarts it, so a short glitch never
    // reaches the debounced level. The press pulse fires on the same edge
    // the debounced level rises.
    always_ff @(posedge clock_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta    <= 1'b0;
            sync_level   <= 1'b0;
            debounced    <= 1'b0;
            stable_count <= '0;
            button_press <= 1'b0;
        end else begin
            sync_meta    <= button_raw;
            sync_level   <= sync_meta;
            button_press <= 1'b0;
            if (sync_level == debounced) begin
                stable_count <= '0;
            end else if (stable_count == LAST_COUNT) begin
                debounced    <= sync_level;
                stable_count <= '0;
                button_press <= sync_level;
            end else begin
                stable_count <= stable_count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/clock_break_controller.sv
// ----------------------------------------------------------------------------
// clock_break_controller
//
// Purpose:
//   Break FSM for the core clock. Halts the core when it raises
//   break_request, lets the user single-step it with a push-button, and
//   resumes it on the resume button (or, when auto-resume is built in, when
//   the break countdown timer expires).
//
// Configuration:
//   BREAK_AUTO_RESUME_EN  when defined, the countdown runs while halted and
//                         its timeout resumes the core. When undefined,
//                         countdown_enable is held at 0 and
//                         countdown_timed_up is ignored.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles before a button change is accepted
//   STEP_CYCLES      core clock-enable cycles granted per step press (>=1)
//
// Ports:
//   clock_50mhz         in   system clock
//   reset_n             in   asynchronous active-low reset
//   break_request       in   break level from the core
//   step_button         in   raw step push-button
//   resume_button       in   raw resume push-button
//   countdown_timed_up  in   one-cycle timeout pulse from the countdown
//   countdown_enable    out  countdown runs while high
//   core_clock_enable   out  core advances on cycles where this is high
//   halted              out  high while in HALT
//   break_count         out  number of RUN->HALT entries, wrapping
// ----------------------------------------------------------------------------
module clock_break_controller
    import clock_break_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int STEP_CYCLES     = STEP_CYCLES_DEFAULT
) (
    input  logic       clock_50mhz,
    input  logic       reset_n,
    input  logic       break_request,
    input  logic       step_button,
    input  logic       resume_button,
    input  logic       countdown_timed_up,
    output logic       countdown_enable,
    output logic       core_clock_enable,
    output logic       halted,
    output logic [7:0] break_count
);

    localparam int SW = $clog2(STEP_CYCLES + 1);
    localparam logic [SW-1:0] LAST_STEP = SW'(STEP_CYCLES - 1);

    brk_state_e    state;
    brk_state_e    next_state;
    logic          break_request_q;
    logic          reentry_guard;
    logic          next_reentry_guard;
    logic [SW-1:0] step_count;
    logic [SW-1:0] next_step_count;
    logic [7:0]    next_break_count;
    logic          next_core_clock_enable;
    logic          next_halted;
    logic          next_countdown_enable;
    logic          step_press;
    logic          resume_press;
    logic          auto_resume_event;

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_step_debouncer (
        .clock_50mhz  (clock_50mhz),
        .reset_n      (reset_n),
        .button_raw   (step_button),
        .button_press (step_press)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_resume_debouncer (
        .clock_50mhz  (clock_50mhz),
        .reset_n      (reset_n),
        .button_raw   (resume_button),
        .button_press (resume_press)
    );

`ifdef BREAK_AUTO_RESUME_EN
    assign auto_resume_event = countdown_timed_up;
`else
    logic unused_countdown_timed_up;
    assign unused_countdown_timed_up = countdown_timed_up;
    assign auto_resume_event         = 1'b0;
`endif

    // Next-state logic. break_request is taken from its registered copy,
    // which is why the core keeps running for one cycle after it asks to
    // break. The re-entry guard lasts one RUN cycle after leaving HALT so a
    // break level that is still high does not immediately halt again.
    // Presses and break requests seen during STEP are simply dropped.
    always_comb begin
        next_state         = state;
        next_reentry_guard = 1'b0;
        next_step_count    = step_count;
        next_break_count   = break_count;
        unique case (state)
            BRK_STATE_RUN: begin
                if (break_request_q && !reentry_guard) begin
                    next_state       = BRK_STATE_HALT;
                    next_break_count = break_count + 8'd1;
                end
            end
            BRK_STATE_HALT: begin
                if (resume_press) begin
                    next_state         = BRK_STATE_RUN;
                    next_reentry_guard = 1'b1;
                end else if (step_press) begin
                    next_state      = BRK_STATE_STEP;
                    next_step_count = '0;
                end else if (auto_resume_event) begin
                    next_state         = BRK_STATE_RUN;
                    next_reentry_guard = 1'b1;
                end
            end
            BRK_STATE_STEP: begin
                if (step_count == LAST_STEP) begin
                    next_state = BRK_STATE_HALT;
                end else begin
                    next_step_count = step_count + SW'(1);
                end
            end
            default: begin
                next_state = BRK_STATE_RUN;
            end
        endcase
    end

    // Outputs are decoded from the next state so that the registered
    // outputs line up with the state register on the same edge.
    always_comb begin
        next_core_clock_enable = core_runs_in(next_state);
        next_halted            = (next_state == BRK_STATE_HALT);
`ifdef BREAK_AUTO_RESUME_EN
        next_countdown_enable  = next_halted;
`else
        next_countdown_enable  = 1'b0;
`endif
    end

    // State, counters and output registers. Reset clears everything and
    // returns to RUN with all outputs low; the core is enabled from the
    // first edge after reset releases.
    always_ff @(posedge clock_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            state             <= BRK_STATE_RUN;
            break_request_q   <= 1'b0;
            reentry_guard     <= 1'b0;
            step_count        <= '0;
            break_count       <= 8'd0;
            core_clock_enable <= 1'b0;
            halted            <= 1'b0;
            countdown_enable  <= 1'b0;
        end else begin
            state             <= next_state;
            break_request_q   <= break_request;
            reentry_guard     <= next_reentry_guard;
            step_count        <= next_step_count;
            break_count       <= next_break_count;
            core_clock_enable <= next_core_clock_enable;
            halted            <= next_halted;
            countdown_enable  <= next_countdown_enable;
        end
    end

endmodule
